// File: rtl/apb_slave_regfile.sv
// APB completer fronting a bank of DEPTH 8-bit registers.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  if (DEPTH < 1 || DEPTH > 256) begin : g_depth_chk
    $error("apb_slave_regfile: DEPTH must be 1..256");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("apb_slave_regfile: WAIT_CYCLES must be 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef APB_SLAVE_WAIT_EN
    S_WAIT,
`endif
    S_ACCESS
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   addr_q;
  logic            wr_q;
  logic            range_ok_q;
  logic [7:0]      mem [DEPTH];

  logic            setup;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic            commit;

  assign setup    = (state_q == S_IDLE) & psel & ~penable;
  assign in_range = {1'b0, paddr} < DEPTH_W;
  assign idx      = paddr[AW-1:0];
  assign commit   = (state_q == S_ACCESS) & psel & penable
                  & wr_q & range_ok_q;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else if (setup) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
`ifdef APB_SLAVE_WAIT_EN
        if (setup) state_d = S_WAIT;
`else
        if (setup) state_d = S_ACCESS;
`endif
      end
`ifdef APB_SLAVE_WAIT_EN
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACCESS;
        end
      end
`endif
      S_ACCESS: begin
        pready  = 1'b1;
        pslverr = ~range_ok_q;
        // completion or abort both end the transfer
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      range_ok_q <= 1'b0;
      prdata     <= 8'h00;
    end else if (setup) begin
      addr_q     <= idx;
      wr_q       <= pwrite;
      range_ok_q <= in_range;
      if (!pwrite) begin
        prdata <= in_range ? mem[idx] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (commit) begin
      mem[addr_q] <= pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized APB bench for apb_slave_regfile against an array model.
// Wait-state expectations follow APB_SLAVE_WAIT_EN.
module tb_apb_slave_regfile;

  localparam int DEPTH = 16;
`ifdef APB_SLAVE_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic       clk;
  logic       rst;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int total;
  int bad;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] ref_rd;

  apb_slave_regfile #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_rd = 8'h00;
  endtask

  // One full transfer; starts just after a rising edge, ends likewise.
  task automatic xfer(input logic wr, input logic [7:0] a,
                      input logic [7:0] d);
    logic err;
    err = (int'(a) >= DEPTH);
    if (!wr) ref_rd = err ? 8'h00 : ref_mem[a[3:0]];
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = ~d;
    @(posedge clk); #1;
    penable = 1'b1;
    pwdata  = d;
    for (int i = 0; i < WAITS; i++) begin
      @(negedge clk);
      chk("wait_rdy", int'(pready), 0);
      chk("wait_rd", int'(prdata), int'(ref_rd));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rdy", int'(pready), 1);
    chk("err", int'(pslverr), int'(err));
    chk("rd", int'(prdata), int'(ref_rd));
    @(posedge clk); #1;
    if (wr && !err) ref_mem[a[3:0]] = d;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 8'(i), 8'h00);
    end
    @(negedge clk);
    chk(tag, int'(prdata), int'(ref_mem[DEPTH-1]));
    @(posedge clk); #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    model_reset();

    #12;
    chk("rst_rdy", int'(pready), 0);
    chk("rst_err", int'(pslverr), 0);
    chk("rst_rd", int'(prdata), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    xfer(1'b1, 8'h03, 8'hA5);
    xfer(1'b0, 8'h03, 8'h00);
    chk("rd_a5", int'(prdata), 8'hA5);

    // reset during the access phase of a write
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h07;
    pwdata  = 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (WAITS) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_rdy", int'(pready), 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_rdy", int'(pready), 0);
    chk("mid_rst_err", int'(pslverr), 0);
    chk("mid_rst_rd", int'(prdata), 0);
    model_reset();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 8'h07, 8'h00);
    xfer(1'b0, 8'h03, 8'h00);

    // out of range
    xfer(1'b1, 8'h00, 8'h11);
    xfer(1'b1, 8'h10, 8'h5A);
    xfer(1'b0, 8'h00, 8'h00);
    xfer(1'b0, 8'h10, 8'h00);
    xfer(1'b0, 8'hFF, 8'h00);
    sweep("oor_sweep");

    // master abort after SETUP
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h02;
    pwdata  = 8'h3C;
    @(posedge clk); #1;
    psel = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rdy", int'(pready), 0);
    @(posedge clk); #1;

    // access strobe with no SETUP
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'h02;
    pwdata  = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("viol_rdy", int'(pready), 0);
    end
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 8'h02, 8'h00);

    // back-to-back
    xfer(1'b1, 8'h00, 8'hC1);
    xfer(1'b1, 8'h01, 8'hC2);
    xfer(1'b1, 8'h02, 8'hC3);
    xfer(1'b0, 8'h00, 8'h00);
    xfer(1'b0, 8'h01, 8'h00);
    xfer(1'b0, 8'h02, 8'h00);

    // randomized traffic
    repeat (300) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 20)),
           8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    sweep("final_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (responder) at the far end of the team's APB master interface.
- Decodes `psel`/`penable`/`pwrite` phases from the master and services 8-bit reads and writes into an internal register file.
- Drives `prdata`, `pready` and `pslverr` back to the master.
- Used as the bus endpoint in the hdl_top bench and as a reusable peripheral register bank.

Parameters:
- `DEPTH`, 16, number of 8-bit registers; valid addresses 0..DEPTH-1; legal range 1..256.
- `WAIT_CYCLES`, 2, wait states inserted before `pready`; used only when `APB_SLAVE_WAIT_EN` is defined; legal range 1..15.

Ports:
- `clk`  input  1  bus clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `psel`  input  1  slave select from master.
- `penable`  input  1  access-phase strobe from master.
- `pwrite`  input  1  1 = write, 0 = read.
- `paddr`  input  8  transfer address.
- `pwdata`  input  8  write data.
- `prdata`  output  8  read data, registered.
- `pready`  output  1  transfer-complete handshake.
- `pslverr`  output  1  error response for out-of-range address.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - state = IDLE; `prdata` = 8'h00; `pready` = 0; `pslverr` = 0.
  - All register file entries = 8'h00; wait counter = 0.
  - Reset asserted mid-transfer aborts the transfer: no write commits and outputs clear immediately.
- States: IDLE, WAIT, ACCESS. Encoding is free; `pready` and `pslverr` are decoded from registered state only, never combinational from bus inputs.
- IDLE:
  - Rising edge with `psel`=1 and `penable`=0 (SETUP phase) latches `paddr`→addr_q, `pwrite`→wr_q, range_ok_q = (`paddr` < DEPTH).
  - On a read with range_ok_q true, the same edge loads `prdata` <= mem[`paddr`]; otherwise `prdata` <= 8'h00.
  - Next state is WAIT if wait insertion is enabled, else ACCESS.
  - `psel`=1 with `penable`=1 while in IDLE (no preceding SETUP) is a protocol violation: ignored, stay in IDLE, no write, no `pready`.
- WAIT:
  - `pready` = 0.
  - Counter loaded with WAIT_CYCLES on IDLE exit; decrements each edge; moves to ACCESS on the edge where the counter equals 1.
- ACCESS:
  - `pready` = 1; `pslverr` = !range_ok_q.
  - Completion edge (`psel`=1, `penable`=1): if wr_q and range_ok_q, then mem[addr_q] <= `pwdata` (pwdata sampled here, not at SETUP). Next state IDLE.
  - Out-of-range write: no register changes. Out-of-range read: `prdata` stays 8'h00.
- Master abort: `psel` sampled 0 in WAIT or ACCESS → IDLE, no write, `pready` = 0 next cycle.
- `prdata` holds its last value between transfers; it is updated only on a read SETUP edge or by reset.
- Zero-wait latency: SETUP cycle, then ACCESS cycle with `pready` = 1, giving a 2-cycle transfer. With waits the transfer takes 2 + WAIT_CYCLES cycles.
- Back-to-back transfers: after the completion edge the block is in IDLE and accepts a new SETUP on the next edge, so there are no dead cycles.

Optional Feature:
- Macro `APB_SLAVE_WAIT_EN`.
- Defined: WAIT state and 4-bit counter are present; every transfer, including error transfers, holds `pready` low for exactly WAIT_CYCLES cycles of the access phase.
- Undefined: WAIT state and counter are not generated; IDLE goes straight to ACCESS; WAIT_CYCLES is ignored; all transfers are zero-wait.

Test Plan:
- Zero-wait write then read: write addr 8'h03 data 8'hA5, then read 8'h03 → `pready` high in cycle 2 of each transfer, `prdata` = 8'hA5, `pslverr` = 0.
- Out of range (DEPTH=16): write 8'h10 data 8'h5A → `pslverr` = 1 with `pready`; later read 8'h10 → `prdata` = 8'h00, `pslverr` = 1; read 8'h00..8'h0F shows no entry changed.
- Wait states (`APB_SLAVE_WAIT_EN`, WAIT_CYCLES=2): read 8'h03 → `pready` low for 2 access-phase cycles, high on the 3rd; `prdata` = 8'hA5 throughout the access phase.
- Reset mid-transfer: write 8'h07 data 8'hFF, assert `rst` low during ACCESS before the completion edge → outputs 0 immediately; after release, read 8'h07 → 8'h00.
- Master abort and protocol violation: SETUP to 8'h02, then `psel` dropped → no write, back to IDLE. `psel`=1/`penable`=1 with no SETUP → `pready` stays 0, mem[8'h02] unchanged.
- Back-to-back: writes to 8'h00, 8'h01, 8'h02 with no idle cycles → each completes in 2 cycles; readback 8'h00..8'h02 returns the written values.
